tick_counter: RTL and testbench

- Sequential counting stage directly upstream of the 4-bit threshold comparator.
- Counts rising edges of an event input and drives the comparator's 4-bit count input.
- Consumes the comparator's match output. On match, freezes the count for a programmable hold window, then clears the count and resumes.
- Provides load, up/down direction and wrap reporting for the SoC control logic.

---
 rtl/tick_counter_pkg.sv | 19 +
 rtl/tick_counter_edge_detect.sv | 22 ++
 rtl/tick_counter.sv | 106 ++++++++++
 tb/tb_tick_counter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tick_counter_pkg.sv
// Shared constants and types for the tick counter and its threshold comparator.
// The comparator threshold lives here so counter, comparator and bench agree.
package tick_counter_pkg;

  localparam int COUNT_W = 4;
  localparam int HOLD_W  = 4;

  localparam int DEF_HOLD_CYCLES = 3;
  localparam int DEF_RESET_VALUE = 0;

  localparam logic [COUNT_W-1:0] THRESHOLD = 4'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/tick_counter_edge_detect.sv
// One-bit rising-edge detector; a held-high input yields a single pulse.
// Reusable for any event input synchronous to clk.
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_i;
    end
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/tick_counter.sv
// Event counter feeding the threshold comparator: counts tick rising edges,
// freezes for a hold window on match, then clears and resumes.
module tick_counter
  import tick_counter_pkg::*;
#(
  parameter int WIDTH       = COUNT_W,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int RESET_VALUE = DEF_RESET_VALUE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             tick,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             match,
  output logic [WIDTH-1:0] count,
  output logic             wrapped,
  output logic             holding,
  output logic [1:0]       state
);

  localparam logic [WIDTH-1:0]  RST_V    = WIDTH'(RESET_VALUE);
  localparam logic [HOLD_W-1:0] HOLD_TOP = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [WIDTH-1:0]  ONE      = WIDTH'(1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               wrap_q, wrap_d;
  logic               rise;

  edge_detect u_tick_edge (
    .clk    (clk),
    .reset  (reset),
    .d_i    (tick),
    .rise_o (rise)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= RST_V;
      hold_q  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hold_q  <= hold_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hold_d  = hold_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = load_value;
      hold_d  = '0;
      state_d = enable ? RUN : IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable) state_d = RUN;
        end
        RUN: begin
          if (!enable) begin
            state_d = IDLE;
          end else if (match) begin
            state_d = HOLD;
            hold_d  = HOLD_TOP;
          end else if (rise) begin
            if (up_down) begin
              count_d = count_q + ONE;
              wrap_d  = (count_q == '1);
            end else begin
              count_d = count_q - ONE;
              wrap_d  = (count_q == '0);
            end
          end
        end
        HOLD: begin
          // Hold runs to completion even if enable drops mid-window.
          if (hold_q == '0) begin
            count_d = RST_V;
            state_d = enable ? RUN : IDLE;
          end else begin
            hold_d = hold_q - HOLD_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign count   = count_q;
  assign wrapped = wrap_q;
  assign holding = (state_q == HOLD);
  assign state   = state_q;

endmodule

// File: tb/tb_tick_counter.sv
// Directed self-checking bench for tick_counter with a behavioural
// threshold comparator closing the match loop.
module tb_tick_counter;
  import tick_counter_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         tick;
  logic         up_down;
  logic         load;
  logic [3:0]   load_value;
  logic         force_match;
  logic         match;
  logic [3:0]   count;
  logic         wrapped;
  logic         holding;
  logic [1:0]   state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign match = force_match | (count == THRESHOLD);

  tick_counter dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .tick       (tick),
    .up_down    (up_down),
    .load       (load),
    .load_value (load_value),
    .match      (match),
    .count      (count),
    .wrapped    (wrapped),
    .holding    (holding),
    .state      (state)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    step();
    total++;
    if ({count, state, holding, wrapped} !== 8'h00) begin
      bad++;
      $display("FAIL reset_init cnt=%0d st=%0d hold=%b wr=%b exp 0/0/0/0",
               count, state, holding, wrapped);
    end
    reset = 1'b0;
    step();
    enable = 1'b1; load = 1'b1; load_value = 4'd5;
    step();
    load = 1'b0;
    total++;
    if (count !== 4'd5) begin
      bad++;
      $display("FAIL reset_preload count=%0d exp=5", count);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({count, state, holding, wrapped} !== 8'h00) begin
      bad++;
      $display("FAIL reset_async cnt=%0d st=%0d hold=%b wr=%b exp 0/0/0/0",
               count, state, holding, wrapped);
    end
    step();
    reset = 1'b0; enable = 1'b0;
    step();
  endtask

  task automatic test_basic_count();
    int n;
    enable = 1'b1; up_down = 1'b1;
    step();
    total++;
    if (state !== 2'd1) begin
      bad++;
      $display("FAIL basic_run state=%0d exp=1", state);
    end
    for (int i = 1; i <= 10; i++) begin
      tick = 1'b1;
      step();
      total++;
      if (count !== 4'(i)) begin
        bad++;
        $display("FAIL basic_step%0d count=%0d exp=%0d", i, count, i);
      end
      tick = 1'b0;
      step();
    end
    n = 0;
    while (holding && n < 10) begin
      n++;
      total++;
      if (count !== 4'd10) begin
        bad++;
        $display("FAIL basic_frozen count=%0d exp=10", count);
      end
      step();
    end
    total++;
    if (n !== 3) begin
      bad++;
      $display("FAIL basic_hold_len cycles=%0d exp=3", n);
    end
    total++;
    if (count !== 4'd0 || state !== 2'd1) begin
      bad++;
      $display("FAIL basic_after_hold cnt=%0d st=%0d exp 0/1", count, state);
    end
  endtask

  task automatic test_held_tick();
    tick = 1'b1;
    repeat (6) step();
    tick = 1'b0;
    step();
    total++;
    if (count !== 4'd1) begin
      bad++;
      $display("FAIL held_tick count=%0d exp=1", count);
    end
    load = 1'b1; load_value = 4'd9;
    step();
    load = 1'b0; tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    total++;
    if (holding !== 1'b1) begin
      bad++;
      $display("FAIL hold_entry holding=%b exp=1", holding);
    end
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    total++;
    if (count !== 4'd10 || holding !== 1'b1) begin
      bad++;
      $display("FAIL hold_tick cnt=%0d hold=%b exp 10/1", count, holding);
    end
    step();
    total++;
    if (count !== 4'd0 || state !== 2'd1) begin
      bad++;
      $display("FAIL hold_exit cnt=%0d st=%0d exp 0/1", count, state);
    end
  endtask

  task automatic test_wrap();
    load = 1'b1; load_value = 4'd15; up_down = 1'b1;
    step();
    load = 1'b0; tick = 1'b1;
    step();
    total++;
    if (count !== 4'd0 || wrapped !== 1'b1) begin
      bad++;
      $display("FAIL wrap_up cnt=%0d wr=%b exp 0/1", count, wrapped);
    end
    tick = 1'b0;
    step();
    total++;
    if (wrapped !== 1'b0) begin
      bad++;
      $display("FAIL wrap_up_pulse wr=%b exp=0", wrapped);
    end
    load = 1'b1; load_value = 4'd0; up_down = 1'b0;
    step();
    load = 1'b0;
    total++;
    if (wrapped !== 1'b0) begin
      bad++;
      $display("FAIL wrap_load wr=%b exp=0", wrapped);
    end
    tick = 1'b1;
    step();
    total++;
    if (count !== 4'd15 || wrapped !== 1'b1) begin
      bad++;
      $display("FAIL wrap_dn cnt=%0d wr=%b exp 15/1", count, wrapped);
    end
    tick = 1'b0;
    step();
    total++;
    if (wrapped !== 1'b0) begin
      bad++;
      $display("FAIL wrap_dn_pulse wr=%b exp=0", wrapped);
    end
    up_down = 1'b1;
  endtask

  task automatic test_priority();
    load = 1'b1; load_value = 4'd3; tick = 1'b1; force_match = 1'b1;
    step();
    load = 1'b0; tick = 1'b0; force_match = 1'b0;
    total++;
    if (count !== 4'd3 || state !== 2'd1 || holding !== 1'b0) begin
      bad++;
      $display("FAIL prio_load cnt=%0d st=%0d hold=%b exp 3/1/0",
               count, state, holding);
    end
    step();
    tick = 1'b1; enable = 1'b0;
    step();
    total++;
    if (count !== 4'd3 || state !== 2'd0) begin
      bad++;
      $display("FAIL prio_disable cnt=%0d st=%0d exp 3/0", count, state);
    end
    tick = 1'b0;
    step();
    enable = 1'b1; tick = 1'b1;
    step();
    tick = 1'b0;
    total++;
    if (count !== 4'd3 || state !== 2'd1) begin
      bad++;
      $display("FAIL idle_rise cnt=%0d st=%0d exp 3/1", count, state);
    end
    step();
  endtask

  task automatic test_reset_mid_hold();
    int n;
    load = 1'b1; load_value = 4'd10;
    step();
    load = 1'b0;
    step();
    step();
    total++;
    if (holding !== 1'b1) begin
      bad++;
      $display("FAIL rmh_in_hold holding=%b exp=1", holding);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (count !== 4'd0 || state !== 2'd0 || holding !== 1'b0) begin
      bad++;
      $display("FAIL rmh_reset cnt=%0d st=%0d hold=%b exp 0/0/0",
               count, state, holding);
    end
    step();
    reset = 1'b0;
    step();
    total++;
    if (state !== 2'd1 || count !== 4'd0) begin
      bad++;
      $display("FAIL rmh_resume st=%0d cnt=%0d exp 1/0", state, count);
    end
    load = 1'b1; load_value = 4'd9;
    step();
    load = 1'b0; tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    n = 0;
    while (holding && n < 10) begin
      n++;
      step();
    end
    total++;
    if (n !== 3 || count !== 4'd0) begin
      bad++;
      $display("FAIL rmh_fresh_hold cycles=%0d cnt=%0d exp 3/0", n, count);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; tick = 1'b0; up_down = 1'b1;
    load = 1'b0; load_value = '0; force_match = 1'b0;
    test_reset();
    test_basic_count();
    test_held_tick();
    test_wrap();
    test_priority();
    test_reset_mid_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
